// File: rtl/f2f_tx_framer.sv
// f2f_tx_framer: TX link framer feeding the F2F LVDS serializer wrapper.
// Ports:
//   clk         system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   link_en     level, 1 = drive lanes and run the link, 0 = tristate lanes
//   retrain     one-cycle pulse, restarts training while in RUN
//   s_data      32-bit payload word
//   s_valid     payload valid
//   s_ready     payload accepted when s_valid && s_ready
//   txdin       registered 40-bit serializer word {header, payload}
//   serd_cmd    registered lane-group tristate controls (1 = tristate)
//   link_up     registered, 1 while in RUN
//   train_done  registered one-cycle pulse on the TRAIN->RUN transition
module f2f_tx_framer #(
    parameter int unsigned TRAIN_CYCLES  = 256,
    parameter logic [7:0]  TRAIN_PATTERN = 8'h5C,
    parameter int unsigned MAX_BURST     = 64,
    parameter logic [7:0]  IDLE_HDR      = 8'hBC,
    parameter logic [3:0]  DATA_TYPE     = 4'hA
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        link_en,
    input  logic        retrain,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [39:0] txdin,
    output logic [1:0]  serd_cmd,
    output logic        link_up,
    output logic        train_done
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_TRAIN,
        ST_RUN
    } state_t;

    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 1);
    localparam logic [7:0]  BURST_MAX  = 8'(MAX_BURST);
    localparam logic [39:0] TRAIN_WORD = {5{TRAIN_PATTERN}};
    localparam logic [39:0] IDLE_WORD  = {IDLE_HDR, 32'h0};

    state_t      state_q;
    logic [39:0] txdin_q;
    logic [1:0]  serd_cmd_q;
    logic        link_up_q;
    logic        train_done_q;
    logic [3:0]  seq_q;
    logic [7:0]  burst_cnt_q;
    logic [15:0] train_cnt_q;
    // Set when TRAIN was entered from RUN: the entry cycle still carries
    // the last data/idle word, so one extra cycle is spent before counting
    // so that exactly TRAIN_CYCLES pattern words reach the wire.
    logic        pend_q;

    logic        accept;
    logic [39:0] data_word;

    // Depends on registered state only; no path from s_valid.
    assign s_ready   = (state_q == ST_RUN) && (burst_cnt_q != BURST_MAX);
    assign accept    = s_valid && s_ready;
    assign data_word = {DATA_TYPE, seq_q, s_data};

    assign txdin      = txdin_q;
    assign serd_cmd   = serd_cmd_q;
    assign link_up    = link_up_q;
    assign train_done = train_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_OFF;
            txdin_q      <= 40'h0;
            serd_cmd_q   <= 2'b11;
            link_up_q    <= 1'b0;
            train_done_q <= 1'b0;
            seq_q        <= 4'h0;
            burst_cnt_q  <= 8'h0;
            train_cnt_q  <= 16'h0;
            pend_q       <= 1'b0;
        end else begin
            train_done_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    if (link_en) begin
                        state_q     <= ST_TRAIN;
                        train_cnt_q <= 16'h0;
                        seq_q       <= 4'h0;
                        burst_cnt_q <= 8'h0;
                        pend_q      <= 1'b0;
                        txdin_q     <= TRAIN_WORD;
                        serd_cmd_q  <= 2'b00;
                    end else begin
                        txdin_q    <= 40'h0;
                        serd_cmd_q <= 2'b11;
                    end
                    link_up_q <= 1'b0;
                end

                ST_TRAIN: begin
                    if (!link_en) begin
                        state_q    <= ST_OFF;
                        txdin_q    <= 40'h0;
                        serd_cmd_q <= 2'b11;
                        link_up_q  <= 1'b0;
                        pend_q     <= 1'b0;
                    end else if (pend_q) begin
                        pend_q  <= 1'b0;
                        txdin_q <= TRAIN_WORD;
                    end else if (train_cnt_q == TRAIN_LAST) begin
                        state_q      <= ST_RUN;
                        txdin_q      <= IDLE_WORD;
                        link_up_q    <= 1'b1;
                        train_done_q <= 1'b1;
                    end else begin
                        train_cnt_q <= train_cnt_q + 16'h1;
                        txdin_q     <= TRAIN_WORD;
                    end
                end

                ST_RUN: begin
                    if (!link_en) begin
                        // A word accepted in this cycle is dropped.
                        state_q    <= ST_OFF;
                        txdin_q    <= 40'h0;
                        serd_cmd_q <= 2'b11;
                        link_up_q  <= 1'b0;
                    end else begin
                        if (accept) begin
                            txdin_q <= data_word;
                        end else begin
                            txdin_q <= IDLE_WORD;
                        end
                        if (retrain) begin
                            state_q     <= ST_TRAIN;
                            link_up_q   <= 1'b0;
                            train_cnt_q <= 16'h0;
                            seq_q       <= 4'h0;
                            burst_cnt_q <= 8'h0;
                            pend_q      <= 1'b1;
                        end else if (accept) begin
                            seq_q       <= seq_q + 4'h1;
                            burst_cnt_q <= burst_cnt_q + 8'h1;
                        end else begin
                            burst_cnt_q <= 8'h0;
                        end
                    end
                end

                default: begin
                    state_q    <= ST_OFF;
                    txdin_q    <= 40'h0;
                    serd_cmd_q <= 2'b11;
                    link_up_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f2f_tx_framer.sv
// tb_f2f_tx_framer: directed self-checking bench for f2f_tx_framer.
// Runs with TRAIN_CYCLES=4 and MAX_BURST=4.
module tb_f2f_tx_framer;

    localparam logic [39:0] PAT  = 40'h5C5C5C5C5C;
    localparam logic [39:0] IDLE = 40'hBC00000000;

    logic        clk;
    logic        reset_n;
    logic        link_en;
    logic        retrain;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [39:0] txdin;
    logic [1:0]  serd_cmd;
    logic        link_up;
    logic        train_done;

    int tests;
    int fails;
    logic [3:0] exp_seq;

    f2f_tx_framer #(
        .TRAIN_CYCLES (4),
        .MAX_BURST    (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .link_en    (link_en),
        .retrain    (retrain),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .txdin      (txdin),
        .serd_cmd   (serd_cmd),
        .link_up    (link_up),
        .train_done (train_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe cycles until link_up (bounded), counting what went by.
    task automatic run_training(output int pat, output int td,
                                output int bad_cmd, output logic up,
                                output logic [39:0] first_run);
        pat = 0;
        td = 0;
        bad_cmd = 0;
        up = 1'b0;
        first_run = 40'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (txdin === PAT) pat++;
            if (train_done === 1'b1) td++;
            if (serd_cmd !== 2'b00) bad_cmd++;
            if (link_up === 1'b1) begin
                up = 1'b1;
                first_run = txdin;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        link_en = 1'b0;
        retrain = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        step();
        step();
        tests++;
        if (txdin !== 40'h0 || serd_cmd !== 2'b11 || s_ready !== 1'b0 ||
            link_up !== 1'b0 || train_done !== 1'b0) begin
            fails++;
            $display("FAIL reset: txdin=%h cmd=%b rdy=%b up=%b td=%b",
                     txdin, serd_cmd, s_ready, link_up, train_done);
        end
        reset_n = 1'b1;
        step();
        tests++;
        if (txdin !== 40'h0 || serd_cmd !== 2'b11 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL off_idle: txdin=%h cmd=%b rdy=%b expected 0/11/0",
                     txdin, serd_cmd, s_ready);
        end
    endtask

    task automatic test_training();
        int pat, td, bad;
        logic up;
        logic [39:0] fr;
        link_en = 1'b1;
        run_training(pat, td, bad, up, fr);
        tests++;
        if (pat != 4 || td != 1 || bad != 0) begin
            fails++;
            $display("FAIL train_seq: pat=%0d td=%0d badcmd=%0d expected 4/1/0",
                     pat, td, bad);
        end
        tests++;
        if (up !== 1'b1 || fr !== IDLE || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL train_run: up=%b txdin=%h rdy=%b expected 1/%h/1",
                     up, fr, s_ready, IDLE);
        end
        exp_seq = 4'h0;
    endtask

    task automatic test_single();
        s_data  = 32'hDEADBEEF;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        tests++;
        if (txdin !== 40'hA0DEADBEEF) begin
            fails++;
            $display("FAIL single0: txdin=%h expected A0DEADBEEF", txdin);
        end
        s_data  = 32'h12345678;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        tests++;
        if (txdin !== 40'hA112345678) begin
            fails++;
            $display("FAIL single1: txdin=%h expected A112345678", txdin);
        end
        step();
        tests++;
        if (txdin !== IDLE) begin
            fails++;
            $display("FAIL single_idle: txdin=%h expected %h", txdin, IDLE);
        end
        exp_seq = 4'h2;
    endtask

    task automatic test_burst();
        logic [31:0] w;
        logic [39:0] exp;
        w = 32'hC0000000;
        s_valid = 1'b1;
        for (int p = 0; p < 24; p++) begin
            tests++;
            if (s_ready !== ((p % 5) != 4)) begin
                fails++;
                $display("FAIL burst_ready p=%0d: rdy=%b", p, s_ready);
            end
            s_data = w;
            step();
            if ((p % 5) != 4) begin
                exp = {4'hA, exp_seq, w};
                exp_seq = exp_seq + 4'h1;
                w = w + 32'h1;
            end else begin
                exp = IDLE;
            end
            tests++;
            if (txdin !== exp) begin
                fails++;
                $display("FAIL burst_word p=%0d: txdin=%h expected %h",
                         p, txdin, exp);
            end
        end
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_retrain();
        int pat, td, bad;
        logic up;
        logic [39:0] fr;
        s_valid = 1'b1;
        s_data  = 32'h11110000;
        step();
        tests++;
        if (txdin !== {4'hA, exp_seq, 32'h11110000}) begin
            fails++;
            $display("FAIL rt_pre: txdin=%h seq=%0d", txdin, exp_seq);
        end
        exp_seq = exp_seq + 4'h1;
        s_data  = 32'h11110001;
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        tests++;
        if (txdin !== {4'hA, exp_seq, 32'h11110001} || s_ready !== 1'b0 ||
            link_up !== 1'b0) begin
            fails++;
            $display("FAIL rt_last: txdin=%h rdy=%b up=%b", txdin, s_ready,
                     link_up);
        end
        run_training(pat, td, bad, up, fr);
        tests++;
        if (pat != 4 || td != 1 || bad != 0 || up !== 1'b1 || fr !== IDLE) begin
            fails++;
            $display("FAIL rt_train: pat=%0d td=%0d bad=%0d up=%b txdin=%h",
                     pat, td, bad, up, fr);
        end
        s_data = 32'h22220000;
        step();
        s_valid = 1'b0;
        tests++;
        if (txdin !== 40'hA022220000) begin
            fails++;
            $display("FAIL rt_resume: txdin=%h expected A022220000", txdin);
        end
        exp_seq = 4'h1;
        step();
    endtask

    task automatic test_link_drop();
        int pat, td, bad;
        logic up;
        logic [39:0] fr;
        s_valid = 1'b1;
        s_data  = 32'h33330000;
        step();
        tests++;
        if (txdin !== {4'hA, exp_seq, 32'h33330000}) begin
            fails++;
            $display("FAIL drop_pre: txdin=%h", txdin);
        end
        s_data  = 32'h33330001;
        link_en = 1'b0;
        step();
        s_valid = 1'b0;
        tests++;
        if (serd_cmd !== 2'b11 || txdin !== 40'h0 || link_up !== 1'b0 ||
            s_ready !== 1'b0) begin
            fails++;
            $display("FAIL drop_off: cmd=%b txdin=%h up=%b rdy=%b",
                     serd_cmd, txdin, link_up, s_ready);
        end
        step();
        tests++;
        if (serd_cmd !== 2'b11 || txdin !== 40'h0) begin
            fails++;
            $display("FAIL drop_hold: cmd=%b txdin=%h", serd_cmd, txdin);
        end
        link_en = 1'b1;
        run_training(pat, td, bad, up, fr);
        tests++;
        if (pat != 4 || td != 1 || bad != 0 || up !== 1'b1 || fr !== IDLE) begin
            fails++;
            $display("FAIL drop_retrain: pat=%0d td=%0d bad=%0d up=%b txdin=%h",
                     pat, td, bad, up, fr);
        end
        s_valid = 1'b1;
        s_data  = 32'h44440000;
        step();
        s_valid = 1'b0;
        tests++;
        if (txdin !== 40'hA044440000) begin
            fails++;
            $display("FAIL drop_resume: txdin=%h expected A044440000", txdin);
        end
        step();
    endtask

    task automatic test_async_reset();
        int pat, td, bad;
        logic up;
        logic [39:0] fr;
        link_en = 1'b0;
        step();
        link_en = 1'b1;
        step();
        step();
        tests++;
        if (txdin !== PAT || serd_cmd !== 2'b00) begin
            fails++;
            $display("FAIL ar_train: txdin=%h cmd=%b", txdin, serd_cmd);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (txdin !== 40'h0 || serd_cmd !== 2'b11 || link_up !== 1'b0 ||
            s_ready !== 1'b0 || train_done !== 1'b0) begin
            fails++;
            $display("FAIL ar_immediate: txdin=%h cmd=%b up=%b rdy=%b",
                     txdin, serd_cmd, link_up, s_ready);
        end
        step();
        reset_n = 1'b1;
        run_training(pat, td, bad, up, fr);
        tests++;
        if (pat != 4 || td != 1 || bad != 0 || up !== 1'b1 || fr !== IDLE) begin
            fails++;
            $display("FAIL ar_retrain: pat=%0d td=%0d bad=%0d up=%b txdin=%h",
                     pat, td, bad, up, fr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_seq = 4'h0;
        test_reset();
        test_training();
        test_single();
        test_burst();
        test_retrain();
        test_link_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
